// File: rtl/pspin_ctrl_regfile.sv
// PsPIN control/status register file.
// Drives cluster fetch enable and the auxiliary reset, turns cluster
// end-of-compute into sticky maskable interrupt sources, exposes the
// MPQ-full vector and pops the first-word-fall-through stdout FIFOs.
// All PsPIN-side inputs are already synchronised to clk.
module pspin_ctrl_regfile #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STRB_WIDTH   = DATA_WIDTH / 8,
   parameter int NUM_CLUSTERS = 2,
   parameter int NUM_MPQ      = 256,
   parameter int NUM_STDOUT   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDR_WIDTH-1:0]    reg_wr_addr,
   input  logic [DATA_WIDTH-1:0]    reg_wr_data,
   input  logic [STRB_WIDTH-1:0]    reg_wr_strb,
   input  logic                     reg_wr_en,
   output logic                     reg_wr_ack,
   input  logic [ADDR_WIDTH-1:0]    reg_rd_addr,
   input  logic                     reg_rd_en,
   output logic [DATA_WIDTH-1:0]    reg_rd_data,
   output logic                     reg_rd_ack,
   output logic [NUM_CLUSTERS-1:0]  cl_fetch_en_o,
   output logic                     aux_rst_o,
   output logic                     irq_o,
   input  logic [NUM_CLUSTERS-1:0]  cl_eoc_i,
   input  logic [NUM_CLUSTERS-1:0]  cl_busy_i,
   input  logic [NUM_MPQ-1:0]       mpq_full_i,
   input  logic [NUM_STDOUT-1:0]    stdout_empty_i,
   input  logic [NUM_STDOUT-1:0]    stdout_rst_busy_i,
   input  logic [32*NUM_STDOUT-1:0] stdout_dout_i,
   output logic [NUM_STDOUT-1:0]    stdout_rd_en_o
);

   localparam int MPQ_WORDS = (NUM_MPQ + 31) / 32;

   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
   localparam logic [ADDR_WIDTH-1:0] A_FETCH_EN  = ADDR_WIDTH'(32'h0000);
   localparam logic [ADDR_WIDTH-1:0] A_AUX_RST   = ADDR_WIDTH'(32'h0004);
   localparam logic [ADDR_WIDTH-1:0] A_EOC_STICK = ADDR_WIDTH'(32'h0008);
   localparam logic [ADDR_WIDTH-1:0] A_IRQ_MASK  = ADDR_WIDTH'(32'h000C);
   localparam logic [ADDR_WIDTH-1:0] A_EOC_LIVE  = ADDR_WIDTH'(32'h0100);
   localparam logic [ADDR_WIDTH-1:0] A_BUSY_LIVE = ADDR_WIDTH'(32'h0104);
   localparam logic [ADDR_WIDTH-1:0] A_STDOUT_ST = ADDR_WIDTH'(32'h0108);

   // Unsupported configurations stop elaboration.
   if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("pspin_ctrl_regfile: DATA_WIDTH must be 32");
   end
   if (NUM_CLUSTERS < 1 || NUM_CLUSTERS > 32) begin : g_bad_clusters
      $error("pspin_ctrl_regfile: NUM_CLUSTERS must be 1..32");
   end
   if (NUM_STDOUT < 1 || NUM_STDOUT > 16) begin : g_bad_stdout
      $error("pspin_ctrl_regfile: NUM_STDOUT must be 1..16");
   end

   logic [NUM_CLUSTERS-1:0] cl_fetch_en_q, cl_fetch_en_d;
   logic                    aux_rst_q, aux_rst_d;
   logic [NUM_CLUSTERS-1:0] eoc_sticky_q, eoc_sticky_d;
   logic [NUM_CLUSTERS-1:0] irq_mask_q, irq_mask_d;
   logic [NUM_CLUSTERS-1:0] eoc_prev_q, eoc_prev_d;
   logic                    irq_q, irq_d;
   logic                    wr_ack_q, wr_ack_d;
   logic                    rd_ack_q, rd_ack_d;
   logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
   logic [NUM_STDOUT-1:0]   stdout_rd_en_q, stdout_rd_en_d;

   logic [ADDR_WIDTH-1:0]   wr_a, rd_a;
   logic [DATA_WIDTH-1:0]   wr_mask;
   logic [NUM_CLUSTERS-1:0] eoc_clr;
   logic [DATA_WIDTH-1:0]   rd_val;
   logic [NUM_STDOUT-1:0]   pop;
   logic [NUM_STDOUT-1:0]   stdout_ready;
   logic [MPQ_WORDS*32-1:0] mpq_pad;

   assign wr_a = reg_wr_addr & ALIGN_MASK;
   assign rd_a = reg_rd_addr & ALIGN_MASK;

   // Write decode: byte strobes expand to a bit mask, RO/unmapped writes only ack.
   always_comb begin
      wr_mask       = '0;
      wr_ack_d      = reg_wr_en;
      cl_fetch_en_d = cl_fetch_en_q;
      aux_rst_d     = aux_rst_q;
      irq_mask_d    = irq_mask_q;
      eoc_clr       = '0;
      for (int b = 0; b < STRB_WIDTH; b++) begin
         wr_mask[8*b +: 8] = {8{reg_wr_strb[b]}};
      end
      if (reg_wr_en) begin
         if (wr_a == A_FETCH_EN) begin
            cl_fetch_en_d = (cl_fetch_en_q & ~wr_mask[NUM_CLUSTERS-1:0]) |
                            (reg_wr_data[NUM_CLUSTERS-1:0] & wr_mask[NUM_CLUSTERS-1:0]);
         end
         if (wr_a == A_AUX_RST && wr_mask[0]) begin
            aux_rst_d = reg_wr_data[0];
         end
         if (wr_a == A_EOC_STICK) begin
            eoc_clr = reg_wr_data[NUM_CLUSTERS-1:0] & wr_mask[NUM_CLUSTERS-1:0];
         end
         if (wr_a == A_IRQ_MASK) begin
            irq_mask_d = (irq_mask_q & ~wr_mask[NUM_CLUSTERS-1:0]) |
                         (reg_wr_data[NUM_CLUSTERS-1:0] & wr_mask[NUM_CLUSTERS-1:0]);
         end
      end
   end

   // Sticky end-of-compute: a rising edge sets a bit and beats a same-cycle W1C.
   always_comb begin
      eoc_prev_d   = cl_eoc_i;
      eoc_sticky_d = (eoc_sticky_q & ~eoc_clr) | (cl_eoc_i & ~eoc_prev_q);
      irq_d        = |(eoc_sticky_q & irq_mask_q);
   end

   // Read decode: default all-ones for unmapped; stdout reads pop at most one channel.
   always_comb begin
      rd_ack_d       = reg_rd_en;
      rd_data_d      = rd_data_q;
      stdout_rd_en_d = '0;
      rd_val         = '1;
      pop            = '0;
      mpq_pad        = '0;
      mpq_pad[NUM_MPQ-1:0] = mpq_full_i;
      stdout_ready   = ~stdout_empty_i & ~stdout_rst_busy_i;
      if (rd_a == A_FETCH_EN)       rd_val = 32'(cl_fetch_en_q);
      else if (rd_a == A_AUX_RST)   rd_val = 32'(aux_rst_q);
      else if (rd_a == A_EOC_STICK) rd_val = 32'(eoc_sticky_q);
      else if (rd_a == A_IRQ_MASK)  rd_val = 32'(irq_mask_q);
      else if (rd_a == A_EOC_LIVE)  rd_val = 32'(cl_eoc_i);
      else if (rd_a == A_BUSY_LIVE) rd_val = 32'(cl_busy_i);
      else if (rd_a == A_STDOUT_ST) rd_val = 32'(stdout_ready);
      for (int k = 0; k < MPQ_WORDS; k++) begin
         if (rd_a == ADDR_WIDTH'(32'h0200 + 32'(4 * k))) begin
            rd_val = mpq_pad[32*k +: 32];
         end
      end
      for (int c = 0; c < NUM_STDOUT; c++) begin
         if (rd_a == ADDR_WIDTH'(32'h1000 + 32'(4 * c))) begin
            if (stdout_ready[c]) begin
               rd_val = stdout_dout_i[32*c +: 32];
               pop[c] = 1'b1;
            end
         end
      end
      if (reg_rd_en) begin
         rd_data_d      = rd_val;
         stdout_rd_en_d = pop;
      end
   end

   // Control and interrupt state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cl_fetch_en_q <= '0;
         aux_rst_q     <= 1'b1;
         eoc_sticky_q  <= '0;
         irq_mask_q    <= '0;
         eoc_prev_q    <= '0;
         irq_q         <= 1'b0;
      end else begin
         cl_fetch_en_q <= cl_fetch_en_d;
         aux_rst_q     <= aux_rst_d;
         eoc_sticky_q  <= eoc_sticky_d;
         irq_mask_q    <= irq_mask_d;
         eoc_prev_q    <= eoc_prev_d;
         irq_q         <= irq_d;
      end
   end

   // Bus handshake, read data and FIFO pop strobes; reset drops them at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ack_q       <= 1'b0;
         rd_ack_q       <= 1'b0;
         rd_data_q      <= '0;
         stdout_rd_en_q <= '0;
      end else begin
         wr_ack_q       <= wr_ack_d;
         rd_ack_q       <= rd_ack_d;
         rd_data_q      <= rd_data_d;
         stdout_rd_en_q <= stdout_rd_en_d;
      end
   end

   assign reg_wr_ack     = wr_ack_q;
   assign reg_rd_ack     = rd_ack_q;
   assign reg_rd_data    = rd_data_q;
   assign cl_fetch_en_o  = cl_fetch_en_q;
   assign aux_rst_o      = aux_rst_q;
   assign irq_o          = irq_q;
   assign stdout_rd_en_o = stdout_rd_en_q;

endmodule

// File: tb/tb_pspin_ctrl_regfile.sv
// Self-checking bench for pspin_ctrl_regfile with 4 clusters, 40 MPQ
// flags and 2 stdout channels. The stdout FIFOs are modelled as arrays
// whose head advances on the DUT's pop strobes.
module tb_pspin_ctrl_regfile;

   localparam int NC = 4;
   localparam int NM = 40;
   localparam int NS = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [31:0]     reg_wr_addr, reg_wr_data, reg_rd_addr;
   logic [3:0]      reg_wr_strb;
   logic            reg_wr_en, reg_rd_en;
   logic            reg_wr_ack, reg_rd_ack;
   logic [31:0]     reg_rd_data;
   logic [NC-1:0]   cl_fetch_en_o, cl_eoc_i, cl_busy_i;
   logic            aux_rst_o, irq_o;
   logic [NM-1:0]   mpq_full_i;
   logic [NS-1:0]   stdout_empty_i, stdout_rst_busy_i, stdout_rd_en_o;
   logic [32*NS-1:0] stdout_dout_i;

   int checks = 0;
   int failures = 0;

   logic [31:0] fifo_mem [NS][17];
   int          fifo_head [NS];
   int          fifo_tail [NS];
   int          rd_idx [NS];

   logic [NC-1:0] m_fetch, m_mask, m_sticky, m_prev;
   logic          m_aux;

   always #5 clk = ~clk;

   pspin_ctrl_regfile #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4),
      .NUM_CLUSTERS(NC), .NUM_MPQ(NM), .NUM_STDOUT(NS)
   ) dut (
      .clk(clk), .rst(rst),
      .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_strb(reg_wr_strb),
      .reg_wr_en(reg_wr_en), .reg_wr_ack(reg_wr_ack),
      .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en),
      .reg_rd_data(reg_rd_data), .reg_rd_ack(reg_rd_ack),
      .cl_fetch_en_o(cl_fetch_en_o), .aux_rst_o(aux_rst_o), .irq_o(irq_o),
      .cl_eoc_i(cl_eoc_i), .cl_busy_i(cl_busy_i), .mpq_full_i(mpq_full_i),
      .stdout_empty_i(stdout_empty_i), .stdout_rst_busy_i(stdout_rst_busy_i),
      .stdout_dout_i(stdout_dout_i), .stdout_rd_en_o(stdout_rd_en_o)
   );

   for (genvar g = 0; g < NS; g++) begin : g_fifo
      assign stdout_empty_i[g]        = (fifo_head[g] == fifo_tail[g]);
      assign stdout_dout_i[32*g +: 32] = fifo_mem[g][fifo_head[g]];
   end

   // FWFT FIFO environment: a pop strobe seen at a rising edge removes the head word.
   always @(posedge clk) begin
      for (int c = 0; c < NS; c++) begin
         if (stdout_rd_en_o[c] && fifo_head[c] < fifo_tail[c]) fifo_head[c] <= fifo_head[c] + 1;
      end
   end

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic ack);
      @(negedge clk);
      reg_wr_addr = a; reg_wr_data = d; reg_wr_strb = s; reg_wr_en = 1'b1;
      @(negedge clk);
      reg_wr_en = 1'b0;
      ack = reg_wr_ack;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                          output logic ack, output logic [NS-1:0] pops);
      @(negedge clk);
      reg_rd_addr = a; reg_rd_en = 1'b1;
      @(negedge clk);
      reg_rd_en = 1'b0;
      data = reg_rd_data; ack = reg_rd_ack; pops = stdout_rd_en_o;
   endtask

   task automatic fifo_push(input int c, input logic [31:0] w);
      fifo_mem[c][fifo_tail[c]] = w;
      fifo_tail[c] = fifo_tail[c] + 1;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic ack; logic [NS-1:0] p;
      #1;
      checks++; if (cl_fetch_en_o !== 4'h0) begin failures++; $display("[TB] FAIL reset_fetch got=%h exp=0", cl_fetch_en_o); end
      checks++; if (aux_rst_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_aux got=%b exp=1", aux_rst_o); end
      checks++; if ({irq_o, reg_wr_ack, reg_rd_ack, stdout_rd_en_o} !== 5'b0) begin failures++; $display("[TB] FAIL reset_strobes got=%b exp=00000", {irq_o, reg_wr_ack, reg_rd_ack, stdout_rd_en_o}); end
      checks++; if (reg_rd_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_rd_data got=%h exp=0", reg_rd_data); end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      do_read(32'h4, d, ack, p);
      checks++; if (d !== 32'h1 || ack !== 1'b1) begin failures++; $display("[TB] FAIL rd_aux got=%h ack=%b exp=1 ack=1", d, ack); end
      @(negedge clk);
      checks++; if (reg_rd_ack !== 1'b0 || reg_rd_data !== 32'h1) begin failures++; $display("[TB] FAIL rd_hold ack=%b data=%h exp ack=0 data=1", reg_rd_ack, reg_rd_data); end
      do_read(32'h0, d, ack, p);
      checks++; if (d !== 32'h0) begin failures++; $display("[TB] FAIL rd_fetch got=%h exp=0", d); end
      do_read(32'hC, d, ack, p);
      checks++; if (d !== 32'h0) begin failures++; $display("[TB] FAIL rd_mask got=%h exp=0", d); end
      do_write(32'h4, 32'h0, 4'hF, ack);
      checks++; if (ack !== 1'b1 || aux_rst_o !== 1'b0) begin failures++; $display("[TB] FAIL wr_aux ack=%b aux=%b exp ack=1 aux=0", ack, aux_rst_o); end
      @(negedge clk);
      checks++; if (reg_wr_ack !== 1'b0) begin failures++; $display("[TB] FAIL wr_ack_width got=%b exp=0", reg_wr_ack); end
      m_aux = 1'b0; m_fetch = '0; m_mask = '0;
   endtask

   task automatic test_fetch_strobe();
      logic [31:0] d, wd, a, exp; logic ack; logic [NS-1:0] p; logic [3:0] s; int sel;
      do_write(32'h0, 32'hFFFF_FFFF, 4'h1, ack);
      checks++; if (cl_fetch_en_o !== 4'hF || ack !== 1'b1) begin failures++; $display("[TB] FAIL fetch_strb1 got=%h ack=%b exp=f ack=1", cl_fetch_en_o, ack); end
      do_read(32'h0, d, ack, p);
      checks++; if (d !== 32'h0000_000F) begin failures++; $display("[TB] FAIL fetch_readback got=%h exp=0000000f", d); end
      do_write(32'h0, 32'h0, 4'h0, ack);
      checks++; if (cl_fetch_en_o !== 4'hF || ack !== 1'b1) begin failures++; $display("[TB] FAIL fetch_strb0 got=%h ack=%b exp=f ack=1", cl_fetch_en_o, ack); end
      m_fetch = 4'hF;
      for (int i = 0; i < 24; i++) begin
         sel = $urandom_range(0, 4);
         wd  = $urandom;
         s   = 4'($urandom);
         case (sel)
            0: a = 32'h000;
            1: a = 32'h004;
            2: a = 32'h00C;
            3: a = 32'h100;
            default: a = 32'h050;
         endcase
         do_write(a | 32'($urandom_range(0, 3)), wd, s, ack);
         if (s[0]) begin
            if (sel == 0) m_fetch = wd[3:0];
            if (sel == 1) m_aux = wd[0];
            if (sel == 2) m_mask = wd[3:0];
         end
         checks++; if (ack !== 1'b1 || cl_fetch_en_o !== m_fetch || aux_rst_o !== m_aux) begin failures++; $display("[TB] FAIL rand_write sel=%0d ack=%b fetch=%h aux=%b exp fetch=%h aux=%b", sel, ack, cl_fetch_en_o, aux_rst_o, m_fetch, m_aux); end
         case (sel)
            0: exp = 32'(m_fetch);
            1: exp = 32'(m_aux);
            2: exp = 32'(m_mask);
            3: exp = 32'h0;
            default: exp = 32'hFFFF_FFFF;
         endcase
         do_read(a, d, ack, p);
         checks++; if (d !== exp || ack !== 1'b1) begin failures++; $display("[TB] FAIL rand_readback sel=%0d got=%h exp=%h", sel, d, exp); end
      end
   endtask

   task automatic test_eoc_irq();
      logic [31:0] d, r; logic ack; logic [NS-1:0] p; logic [3:0] s;
      do_write(32'hC, 32'h0, 4'hF, ack);
      @(negedge clk); cl_eoc_i = 4'b0100;
      do_write(32'hC, 32'h4, 4'hF, ack);
      checks++; if (irq_o !== 1'b0) begin failures++; $display("[TB] FAIL irq_latency_early got=%b exp=0", irq_o); end
      @(negedge clk);
      checks++; if (irq_o !== 1'b1) begin failures++; $display("[TB] FAIL irq_assert got=%b exp=1", irq_o); end
      do_read(32'h8, d, ack, p);
      checks++; if (d !== 32'h4) begin failures++; $display("[TB] FAIL sticky_set got=%h exp=4", d); end
      do_read(32'h100, d, ack, p);
      checks++; if (d !== 32'h4) begin failures++; $display("[TB] FAIL eoc_live got=%h exp=4", d); end
      do_write(32'h8, 32'h4, 4'hF, ack);
      @(negedge clk);
      checks++; if (irq_o !== 1'b0) begin failures++; $display("[TB] FAIL irq_clear got=%b exp=0", irq_o); end
      do_read(32'h8, d, ack, p);
      checks++; if (d !== 32'h0) begin failures++; $display("[TB] FAIL w1c_held got=%h exp=0", d); end
      @(negedge clk); cl_eoc_i = 4'b0000;
      @(negedge clk); cl_eoc_i = 4'b0100;
      reg_wr_addr = 32'h8; reg_wr_data = 32'h4; reg_wr_strb = 4'hF; reg_wr_en = 1'b1;
      @(negedge clk); reg_wr_en = 1'b0;
      do_read(32'h8, d, ack, p);
      checks++; if (d !== 32'h4) begin failures++; $display("[TB] FAIL set_wins got=%h exp=4", d); end
      m_sticky = 4'b0100; m_prev = 4'b0100; m_mask = 4'b0100;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk); cl_eoc_i = 4'($urandom);
         @(negedge clk);
         m_sticky = m_sticky | (cl_eoc_i & ~m_prev);
         m_prev   = cl_eoc_i;
         do_read(32'h8, d, ack, p);
         checks++; if (d !== 32'(m_sticky)) begin failures++; $display("[TB] FAIL rand_sticky it=%0d got=%h exp=%h", i, d, m_sticky); end
         r = $urandom; s = 4'($urandom);
         do_write(32'h8, r, s, ack);
         if (s[0]) m_sticky = m_sticky & ~r[3:0];
         r = $urandom;
         do_write(32'hC, r, 4'hF, ack);
         m_mask = r[3:0];
         @(negedge clk);
         checks++; if (irq_o !== |(m_sticky & m_mask)) begin failures++; $display("[TB] FAIL rand_irq it=%0d got=%b exp=%b", i, irq_o, |(m_sticky & m_mask)); end
      end
      @(negedge clk); cl_eoc_i = 4'b0000;
      @(negedge clk);
      do_write(32'h8, 32'hF, 4'hF, ack);
      do_write(32'hC, 32'h0, 4'hF, ack);
   endtask

   task automatic test_mpq();
      logic [31:0] d; logic ack; logic [NS-1:0] p; logic [NM-1:0] v; logic [NC-1:0] b;
      mpq_full_i = '0; mpq_full_i[39] = 1'b1; mpq_full_i[0] = 1'b1;
      do_read(32'h200, d, ack, p);
      checks++; if (d !== 32'h0000_0001) begin failures++; $display("[TB] FAIL mpq_w0 got=%h exp=00000001", d); end
      do_read(32'h204, d, ack, p);
      checks++; if (d !== 32'h0000_0080) begin failures++; $display("[TB] FAIL mpq_w1 got=%h exp=00000080", d); end
      do_read(32'h208, d, ack, p);
      checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL mpq_w2_unmapped got=%h exp=ffffffff", d); end
      for (int i = 0; i < 8; i++) begin
         v = {8'($urandom), 32'($urandom)};
         b = 4'($urandom);
         @(negedge clk); mpq_full_i = v; cl_busy_i = b;
         do_read(32'h200, d, ack, p);
         checks++; if (d !== 32'(v % 41'h1_0000_0000)) begin failures++; $display("[TB] FAIL rand_mpq_w0 got=%h exp=%h", d, 32'(v % 41'h1_0000_0000)); end
         do_read(32'h205, d, ack, p);
         checks++; if (d !== 32'(v / 41'h1_0000_0000)) begin failures++; $display("[TB] FAIL rand_mpq_w1 got=%h exp=%h", d, 32'(v / 41'h1_0000_0000)); end
         do_read(32'h104, d, ack, p);
         checks++; if (d !== 32'(b)) begin failures++; $display("[TB] FAIL rand_busy got=%h exp=%h", d, b); end
      end
   endtask

   task automatic test_stdout();
      logic [31:0] d, exp; logic ack; logic [NS-1:0] p, pexp; int c;
      fifo_push(1, 32'h11); fifo_push(1, 32'h22);
      do_read(32'h1004, d, ack, p);
      checks++; if (d !== 32'h11 || p !== 2'b10 || ack !== 1'b1) begin failures++; $display("[TB] FAIL stdout_pop1 got=%h pops=%b exp=11 pops=10", d, p); end
      @(negedge clk);
      checks++; if (stdout_rd_en_o !== 2'b00) begin failures++; $display("[TB] FAIL stdout_pop_width got=%b exp=00", stdout_rd_en_o); end
      do_read(32'h1004, d, ack, p);
      checks++; if (d !== 32'h22 || p !== 2'b10) begin failures++; $display("[TB] FAIL stdout_pop2 got=%h pops=%b exp=22 pops=10", d, p); end
      do_read(32'h1004, d, ack, p);
      checks++; if (d !== 32'hFFFF_FFFF || p !== 2'b00) begin failures++; $display("[TB] FAIL stdout_empty got=%h pops=%b exp=ffffffff pops=00", d, p); end
      rd_idx[1] = 2;
      fifo_push(0, 32'hA5); stdout_rst_busy_i = 2'b01;
      do_read(32'h108, d, ack, p);
      checks++; if (d !== 32'h0) begin failures++; $display("[TB] FAIL status_busy got=%h exp=0", d); end
      do_read(32'h1000, d, ack, p);
      checks++; if (d !== 32'hFFFF_FFFF || p !== 2'b00) begin failures++; $display("[TB] FAIL stdout_rst_busy got=%h pops=%b exp=ffffffff pops=00", d, p); end
      stdout_rst_busy_i = 2'b00;
      do_read(32'h108, d, ack, p);
      checks++; if (d !== 32'h1) begin failures++; $display("[TB] FAIL status_ready got=%h exp=1", d); end
      do_read(32'h1000, d, ack, p);
      checks++; if (d !== 32'hA5 || p !== 2'b01) begin failures++; $display("[TB] FAIL stdout_ch0 got=%h pops=%b exp=a5 pops=01", d, p); end
      rd_idx[0] = 1;
      for (int i = 0; i < 12; i++) begin
         c = $urandom_range(0, 1);
         if ($urandom_range(0, 1) == 1 && fifo_tail[c] < 15) fifo_push(c, $urandom);
         c = $urandom_range(0, 1);
         if (rd_idx[c] < fifo_tail[c]) begin
            exp = fifo_mem[c][rd_idx[c]];
            pexp = NS'(1 << c);
            rd_idx[c] = rd_idx[c] + 1;
         end else begin
            exp = 32'hFFFF_FFFF;
            pexp = '0;
         end
         do_read(32'h1000 + 32'(4 * c), d, ack, p);
         checks++; if (d !== exp || p !== pexp) begin failures++; $display("[TB] FAIL rand_stdout ch=%0d got=%h pops=%b exp=%h pops=%b", c, d, p, exp, pexp); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic ack; logic [NS-1:0] p;
      do_write(32'h0, 32'hF, 4'hF, ack);
      do_write(32'hC, 32'hF, 4'hF, ack);
      @(negedge clk); cl_eoc_i = 4'b0010;
      repeat (2) @(negedge clk);
      checks++; if (irq_o !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_irq got=%b exp=1", irq_o); end
      if (fifo_head[0] == fifo_tail[0]) fifo_push(0, 32'h5A);
      @(negedge clk); reg_rd_addr = 32'h1000; reg_rd_en = 1'b1;
      @(posedge clk); #1;
      checks++; if (reg_rd_ack !== 1'b1 || stdout_rd_en_o !== 2'b01) begin failures++; $display("[TB] FAIL pending_read ack=%b pops=%b exp ack=1 pops=01", reg_rd_ack, stdout_rd_en_o); end
      rst = 1'b1; #1;
      checks++; if (reg_rd_ack !== 1'b0 || stdout_rd_en_o !== 2'b00) begin failures++; $display("[TB] FAIL async_reset_strobes ack=%b pops=%b exp ack=0 pops=00", reg_rd_ack, stdout_rd_en_o); end
      checks++; if (cl_fetch_en_o !== 4'h0 || aux_rst_o !== 1'b1 || irq_o !== 1'b0 || reg_rd_data !== 32'h0) begin failures++; $display("[TB] FAIL async_reset_regs fetch=%h aux=%b irq=%b rd=%h exp 0 1 0 0", cl_fetch_en_o, aux_rst_o, irq_o, reg_rd_data); end
      reg_rd_en = 1'b0;
      cl_eoc_i = 4'b0001;
      @(negedge clk); @(negedge clk); rst = 1'b0;
      do_read(32'h8, d, ack, p);
      checks++; if (d !== 32'h1) begin failures++; $display("[TB] FAIL eoc_at_release got=%h exp=1", d); end
      do_read(32'hC, d, ack, p);
      checks++; if (d !== 32'h0) begin failures++; $display("[TB] FAIL mask_after_reset got=%h exp=0", d); end
   endtask

   initial begin
      rst = 1'b1;
      reg_wr_addr = '0; reg_wr_data = '0; reg_wr_strb = '0; reg_wr_en = 1'b0;
      reg_rd_addr = '0; reg_rd_en = 1'b0;
      cl_eoc_i = '0; cl_busy_i = '0; mpq_full_i = '0; stdout_rst_busy_i = '0;
      rd_idx[0] = 0; rd_idx[1] = 0;
      fifo_tail[0] = 0; fifo_tail[1] = 0;
      m_fetch = '0; m_mask = '0; m_sticky = '0; m_prev = '0; m_aux = 1'b1;
      $display("[TB] start");
      test_reset();
      test_fetch_strobe();
      test_eoc_irq();
      test_mpq();
      test_stdout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
